// File: rtl/sipo5_deser.sv
// Serial-in, parallel-out deserializer with valid/ack handshake, all-ones flag,
// busy indication and sticky overrun flag.
module sipo5_deser #(
    parameter int unsigned WIDTH     = 5,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             SP,
    input  logic             SI,
    input  logic             SYNC,
    input  logic             ACK,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic             Z,
    output logic             BUSY,
    output logic             OVF
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qv_q, qv_d;
    logic             z_q, z_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] sr_shift;
    logic             complete;

    // Next-state: bit acceptance, word completion, handshake and overrun.
    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        qv_d     = qv_q;
        z_d      = z_q;
        ovf_d    = ovf_q;
        complete = 1'b0;

        // Word with SI inserted at the end that moves toward the first-bit side.
        if (MSB_FIRST) begin
            sr_shift = {sr_q[WIDTH-2:0], SI};
        end else begin
            sr_shift = {SI, sr_q[WIDTH-1:1]};
        end

        if (SP) begin
            if (SYNC) begin
                // Restart framing: SI is bit 0 of the new word.
                if (MSB_FIRST) begin
                    sr_d = {{(WIDTH-1){1'b0}}, SI};
                end else begin
                    sr_d = {SI, {(WIDTH-1){1'b0}}};
                end
                cnt_d = CntW'(1);
            end else if (cnt_q == CntLast) begin
                complete = 1'b1;
                sr_d     = sr_shift;
                cnt_d    = '0;
            end else begin
                sr_d  = sr_shift;
                cnt_d = cnt_q + CntW'(1);
            end
        end

        if (complete) begin
            q_d  = sr_shift;
            z_d  = &sr_shift;
            qv_d = 1'b1;
            // Overwriting an unacknowledged word is an overrun.
            if (qv_q && !ACK) begin
                ovf_d = 1'b1;
            end
        end else if (qv_q && ACK) begin
            qv_d = 1'b0;
        end

        busy_d = (cnt_d != '0);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CK) begin
        if (CD) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            q_q    <= '0;
            qv_q   <= 1'b0;
            z_q    <= 1'b0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            qv_q   <= qv_d;
            z_q    <= z_d;
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Q    = q_q;
    assign QV   = qv_q;
    assign Z    = z_q;
    assign BUSY = busy_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_sipo5_deser.sv
// Bench for sipo5_deser: MSB-first and LSB-first instances driven in parallel,
// directed steps followed by random traffic, checked against a bit-list model.
module tb_sipo5_deser;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         cd, sp, si, sync, ack;
    logic [W-1:0] q_a, q_b;
    logic         qv_a, qv_b, z_a, z_b, busy_a, busy_b, ovf_a, ovf_b;

    int checks   = 0;
    int failures = 0;

    // Reference model: list of received bits plus output registers.
    bit           m_bits[$];
    logic [W-1:0] m_q_a, m_q_b;
    logic         m_qv, m_z_a, m_z_b, m_ovf;

    always #5 clk = ~clk;

    sipo5_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .CK(clk), .CD(cd), .SP(sp), .SI(si), .SYNC(sync), .ACK(ack),
        .Q(q_a), .QV(qv_a), .Z(z_a), .BUSY(busy_a), .OVF(ovf_a)
    );

    sipo5_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .CK(clk), .CD(cd), .SP(sp), .SI(si), .SYNC(sync), .ACK(ack),
        .Q(q_b), .QV(qv_b), .Z(z_b), .BUSY(busy_b), .OVF(ovf_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit s_sp, input bit s_si, input bit s_sync,
                              input bit s_ack, input bit s_cd);
        bit done;
        done = 1'b0;
        if (s_cd) begin
            m_bits.delete();
            m_q_a = '0; m_q_b = '0; m_qv = 0; m_z_a = 0; m_z_b = 0; m_ovf = 0;
            return;
        end
        if (s_sp) begin
            if (s_sync) begin
                m_bits.delete();
                m_bits.push_back(s_si);
            end else begin
                m_bits.push_back(s_si);
                if (m_bits.size() == W) done = 1'b1;
            end
        end
        if (done) begin
            // i-th received bit goes to Q[W-1-i] (MSB-first) or Q[i] (LSB-first).
            for (int i = 0; i < W; i++) begin
                m_q_a[W-1-i] = m_bits[i];
                m_q_b[i]     = m_bits[i];
            end
            m_bits.delete();
            m_z_a = (m_q_a == {W{1'b1}});
            m_z_b = (m_q_b == {W{1'b1}});
            if (m_qv && !s_ack) m_ovf = 1'b1;
            m_qv = 1'b1;
        end else if (s_ack) begin
            m_qv = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("q_msb", 16'(q_a), 16'(m_q_a));
        chk("qv_msb", 16'(qv_a), 16'(m_qv));
        chk("z_msb", 16'(z_a), 16'(m_z_a));
        chk("busy_msb", 16'(busy_a), 16'(m_bits.size() != 0));
        chk("ovf_msb", 16'(ovf_a), 16'(m_ovf));
        chk("q_lsb", 16'(q_b), 16'(m_q_b));
        chk("qv_lsb", 16'(qv_b), 16'(m_qv));
        chk("z_lsb", 16'(z_b), 16'(m_z_b));
        chk("busy_lsb", 16'(busy_b), 16'(m_bits.size() != 0));
        chk("ovf_lsb", 16'(ovf_b), 16'(m_ovf));
    endtask

    task automatic step(input bit s_sp, input bit s_si, input bit s_sync,
                        input bit s_ack, input bit s_cd);
        sp = s_sp; si = s_si; sync = s_sync; ack = s_ack; cd = s_cd;
        @(posedge clk);
        #1;
        model_step(s_sp, s_si, s_sync, s_ack, s_cd);
        check_all();
    endtask

    task automatic bit_in(input bit b);
        step(1, b, 0, 0, 0);
    endtask

    task automatic ack_pulse();
        step(0, 0, 0, 1, 0);
    endtask

    initial begin
        logic [4:0] w1;
        logic [4:0] w2;
        logic [4:0] w3;
        logic [4:0] w4;
        w1 = 5'b10110;
        w2 = 5'b11001;
        cd = 1; sp = 0; si = 0; sync = 0; ack = 0;
        m_q_a = '0; m_q_b = '0; m_qv = 0; m_z_a = 0; m_z_b = 0; m_ovf = 0;

        // Reset state.
        step(0, 0, 0, 0, 1);
        chk("reset_q", 16'(q_a), 16'h0);
        chk("reset_qv", 16'(qv_a), 16'h0);

        // 1,0,1,1,0 : MSB-first 10110, LSB-first 01101.
        for (int i = 4; i >= 0; i--) begin
            bit_in(w1[i]);
            if (i != 0) chk("busy_mid", 16'(busy_a), 16'h1);
        end
        chk("word1_msb", 16'(q_a), 16'h16);
        chk("word1_lsb", 16'(q_b), 16'h0d);
        chk("word1_z", 16'(z_a), 16'h0);
        chk("word1_busy", 16'(busy_a), 16'h0);

        // All ones then 0,1,1,1,1 with ACK between words.
        ack_pulse();
        for (int i = 0; i < 5; i++) bit_in(1'b1);
        chk("ones_z", 16'(z_a), 16'h1);
        ack_pulse();
        bit_in(1'b0);
        for (int i = 0; i < 4; i++) bit_in(1'b1);
        chk("0111_z", 16'(z_a), 16'h0);
        chk("0111_ovf", 16'(ovf_a), 16'h0);
        ack_pulse();
        chk("ack_clears_qv", 16'(qv_a), 16'h0);

        // SYNC framing drops the earlier partial word.
        for (int i = 0; i < 3; i++) bit_in(1'b1);
        step(1, 0, 1, 0, 0);
        chk("sync_no_word", 16'(qv_a), 16'h0);
        bit_in(0); bit_in(0); bit_in(0); bit_in(1);
        chk("sync_word", 16'(q_a), 16'h01);
        ack_pulse();

        // Same word with SP gaps.
        for (int i = 4; i >= 0; i--) begin
            bit_in(w1[i]);
            step(0, ~w1[i], 1, 0, 0);
        end
        chk("gap_word", 16'(q_a), 16'h16);
        // Second word with no ACK -> overrun.
        for (int i = 4; i >= 0; i--) bit_in(w2[i]);
        chk("ovr_word", 16'(q_a), 16'h19);
        chk("ovr_flag", 16'(ovf_a), 16'h1);

        // ACK coincident with completion: no overrun.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) bit_in(1'b0);
        for (int i = 0; i < 4; i++) bit_in(1'b1);
        step(1, 1, 0, 1, 0);
        chk("coinc_qv", 16'(qv_a), 16'h1);
        chk("coinc_ovf", 16'(ovf_a), 16'h0);

        // Reset mid-word.
        ack_pulse();
        bit_in(1); bit_in(1); bit_in(1);
        step(1, 1, 0, 0, 1);
        chk("cd_busy", 16'(busy_a), 16'h0);
        w3 = 5'b10001;
        for (int i = 4; i >= 0; i--) bit_in(w3[i]);
        chk("after_cd_word", 16'(q_a), 16'h11);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            w4 = 5'($urandom);
            step(($urandom_range(0, 3) != 0), w4[0], ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
